pc_predict_unit: RTL
====================

Name: pc_predict_unit

Overview:
- Next-generation fetch-stage program counter: holds the PC register and selects the next fetch address.
- Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits between instruction memory and the EX stage. EX resolves branches/jumps and drives redirect and BTB-update inputs; all jump/jr/branch target arithmetic is done upstream in EX.

Parameters:
PC_W, 32, PC and target width in bits (>= 8)
RESET_PC, 0, PC value loaded on reset (word-aligned)
BTB_ENTRIES, 16, number of BTB entries; power of 2, >= 2; IDX_W = log2(BTB_ENTRIES)

Ports:
CLK  in  1  clock, rising-edge
nRST  in  1  asynchronous active-low reset
pc_en  in  1  advance PC this cycle (ihit and no stall)
pc  out  PC_W  current fetch address
pred_taken  out  1  current pc predicted taken
pred_npc  out  PC_W  next PC loaded if pc_en and no redirect
redirect  in  1  EX mispredict/jump correction
redirect_pc  in  PC_W  corrected fetch address
upd_en  in  1  EX resolved a conditional branch this cycle
upd_pc  in  PC_W  address of resolved branch
upd_target  in  PC_W  branch target address
upd_taken  in  1  branch outcome

Behaviour:
- Clocking and reset: one clock CLK; reset nRST is asynchronous, active-low.
- On reset assertion, immediately: pc = RESET_PC; all BTB valid bits = 0; all counters = 2'b00.
  - Since every entry is invalid, pred_taken = 0 and pred_npc = RESET_PC+4.
  - Reset mid-operation discards all BTB state, with no partial update.
- Indexing:
  - idx = addr[IDX_W+1:2]; tag = addr[PC_W-1:IDX_W+2].
  - Bits [1:0] are ignored for lookup.
- Entry contents: valid, tag, target[PC_W], ctr[2].
- Lookup (combinational on pc):
  - hit = valid[idx] & (tag match).
  - pred_taken = hit & ctr[1].
  - pred_npc = pred_taken ? target : pc+4.
  - pc+4 wraps modulo 2^PC_W.
- PC register (rising CLK), priority order:
  1. redirect=1: pc <= redirect_pc, regardless of pc_en.
  2. pc_en=1: pc <= pred_npc.
  3. Otherwise pc holds.
- BTB update (rising CLK, when upd_en=1), using lookup of upd_pc:
  - Hit, upd_taken=1: ctr <= sat_inc(ctr), max 2'b11; target <= upd_target.
  - Hit, upd_taken=0: ctr <= sat_dec(ctr), min 2'b00; target unchanged.
  - Miss, upd_taken=1: allocate/replace entry with valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, upd_taken=0: no change (no allocation on not-taken).
- Simultaneous events:
  - Update and lookup to the same idx in the same cycle: the lookup uses pre-update state; the update is visible the next cycle.
  - redirect and upd_en in the same cycle: both take effect.
- Latency:
  - Prediction: 0 cycles (combinational from pc).
  - PC update and BTB update: 1 cycle.
- No X propagation: outputs are defined whenever nRST is high after reset.

Optional Feature:
- Macro: PC_PERF_EN.
- Defined: adds two outputs.
  - redirect_cnt (out, 32): counts cycles with redirect=1.
  - btb_hit_cnt (out, 32): counts cycles with pc_en=1 and hit=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on nRST.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert nRST=0 mid-run with RESET_PC=32'h0000_0100 -> pc=0x100 immediately; pred_taken=0; pred_npc=0x104.
- Sequential fetch: pc_en=1 for 3 cycles from 0x100, no updates -> pc 0x104, 0x108, 0x10C.
- Stall, then redirect priority: pc_en=0 -> pc holds. Next cycle redirect=1, redirect_pc=0x200 with pc_en=1 -> pc=0x200.
- Allocate and predict: upd_en=1, upd_pc=0x200, upd_target=0x080, upd_taken=1; then pc=0x200 -> pred_taken=1, pred_npc=0x080. With pc_en=1 -> pc=0x080.
- Counter hysteresis: starting from the allocated entry (ctr=10):
  - Two not-taken updates -> ctr 01, then 00; pred_taken=0, pred_npc=0x204.
  - Three taken updates -> ctr 01, 10, 11 (saturates); pred_taken=1 after the second.
- Alias/wrap, with BTB_ENTRIES=16:
  - Entry allocated for 0x200; then pc=0x240 (same idx, different tag) -> pred_taken=0.
  - pc=32'hFFFF_FFFC, pc_en=1, no hit -> pc=0x0000_0000.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Fetch PC register plus direct-mapped BTB with 2-bit counters; prediction is combinational, PC/BTB update 1 cycle, pc_en stalls.
// Optional PC_PERF_EN adds saturating redirect and BTB-hit counters.
module pc_predict_unit #(
   parameter int              PC_W        = 32,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              BTB_ENTRIES = 16
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            pc_en,
   output logic [PC_W-1:0] pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_npc,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            upd_en,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
`ifdef PC_PERF_EN
   input  logic            upd_taken,
   output logic [31:0]     redirect_cnt,
   output logic [31:0]     btb_hit_cnt
`else
   input  logic            upd_taken
`endif
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   logic [PC_W-1:0]  r_pc;
   logic             r_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
   logic [PC_W-1:0]  r_target [BTB_ENTRIES];
   logic [1:0]       r_ctr    [BTB_ENTRIES];

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic [IDX_W-1:0] w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic             w_upd_hit;
   logic [1:0]       w_upd_ctr;
   logic             w_unused;

   assign w_idx      = r_pc[IDX_W+1:2];
   assign w_tag      = r_pc[PC_W-1:IDX_W+2];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign pred_taken = w_hit && r_ctr[w_idx][1];
   assign pred_npc   = pred_taken ? r_target[w_idx] : r_pc + PC_W'(4);
   assign pc         = r_pc;

   assign w_upd_idx = upd_pc[IDX_W+1:2];
   assign w_upd_tag = upd_pc[PC_W-1:IDX_W+2];
   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
   assign w_upd_ctr = r_ctr[w_upd_idx];
   assign w_unused  = ^upd_pc[1:0];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= redirect_pc;
      end else if (pc_en) begin
         r_pc <= pred_npc;
      end
   end

   // Lookup above reads pre-update state, so a same-index update shows up next cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b00;
         end
      end else if (upd_en) begin
         if (w_upd_hit) begin
            if (upd_taken) begin
               r_target[w_upd_idx] <= upd_target;
               if (w_upd_ctr != 2'b11) r_ctr[w_upd_idx] <= w_upd_ctr + 2'd1;
            end else if (w_upd_ctr != 2'b00) begin
               r_ctr[w_upd_idx] <= w_upd_ctr - 2'd1;
            end
         end else if (upd_taken) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
            r_ctr[w_upd_idx]    <= 2'b10;
         end
      end
   end

`ifdef PC_PERF_EN
   logic [31:0] r_redirect_cnt;
   logic [31:0] r_btb_hit_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_redirect_cnt <= '0;
         r_btb_hit_cnt  <= '0;
      end else begin
         if (redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         if (pc_en && w_hit && (r_btb_hit_cnt != 32'hFFFF_FFFF))
            r_btb_hit_cnt <= r_btb_hit_cnt + 32'd1;
      end
   end

   assign redirect_cnt = r_redirect_cnt;
   assign btb_hit_cnt  = r_btb_hit_cnt;
`endif

endmodule
